// File: rtl/ottobit_arith_pkg.sv
// ottobit_arith_pkg: shared FSM encoding and elaboration helpers for the Ottobit arithmetic blocks
package ottobit_arith_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/ready/done handshake, operands and flagged result of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start, cin, sub, ready, busy, done, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output start, a, b, cin, sub, input ready, busy, done, sum, cout, ovf);
  modport slave (input start, a, b, cin, sub, output ready, busy, done, sum, cout, ovf);
endinterface

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-bit ripple adder built from full_adder cells
module digit_adder #(parameter int DIGIT = 2) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co = c[DIGIT];
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract processing DIGIT bits per clock with carry-out and signed overflow
module serial_adder
  import ottobit_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = clog2(NDIG) < 1 ? 1 : clog2(NDIG);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_n;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] d;
  logic carry, c, a_msb, b_msb, last;
  digit_adder #(.DIGIT(DIGIT)) u_dig (
    .x(a_sh[DIGIT-1:0]), .y(b_sh[DIGIT-1:0]), .ci(carry), .s(d), .co(c)
  );
  // result digits enter at the top and drift down, so after NDIG steps the LSB digit sits at bit 0
  assign res_n = WIDTH'({d, res} >> DIGIT);
  assign last = cnt == CW'(NDIG - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == S_IDLE ? (bus.start ? S_RUN : S_IDLE) :
              state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      cnt <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      // subtraction is A + ~B + !borrow, so the effective B and carry are folded in here
      a_sh <= bus.a;
      b_sh <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.cin ^ bus.sub;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1] ^ bus.sub;
      cnt <= '0;
    end else if (state == S_RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      carry <= c;
      cnt <= cnt + CW'(1);
      res <= res_n;
      if (last) begin
        bus.sum <= res_n;
        bus.cout <= c;
        bus.ovf <= (a_msb == b_msb) && (res_n[WIDTH-1] != a_msb);
      end
    end
  assign bus.ready = state == S_IDLE;
  assign bus.busy = state == S_RUN;
  assign bus.done = state == S_DONE;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against an arithmetic reference model
module tb_serial_adder;
  logic clk = 0, rst = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(4)) b41 ();
  serial_adder_if #(.WIDTH(4)) b42 ();
  serial_adder_if #(.WIDTH(4)) b44 ();
  serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  serial_adder #(.WIDTH(4), .DIGIT(1)) dut41 (.clk(clk), .rst(rst), .bus(b41));
  serial_adder #(.WIDTH(4), .DIGIT(2)) dut42 (.clk(clk), .rst(rst), .bus(b42));
  serial_adder #(.WIDTH(4), .DIGIT(4)) dut44 (.clk(clk), .rst(rst), .bus(b44));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // plain integer arithmetic: unsigned for sum/cout, signed range test for overflow
  function automatic void model(input int w, input int a, input int b, input int ci, input int sb,
                                output int s, output int co, output int ov);
    int u, sa, sbv, sr;
    u = sb ? a - b - ci : a + b + ci;
    sa = a >= (1 << (w - 1)) ? a - (1 << w) : a;
    sbv = b >= (1 << (w - 1)) ? b - (1 << w) : b;
    sr = sb ? sa - sbv - ci : sa + sbv + ci;
    s = u & ((1 << w) - 1);
    co = sb ? int'(u >= 0) : int'(u >= (1 << w));
    ov = int'(sr < -(1 << (w - 1)) || sr >= (1 << (w - 1)));
  endfunction
  task automatic chk_res(input string tag, input int w, input logic [7:0] s, input logic co, input logic ov,
                         input int a, input int b, input int ci, input int sb);
    int es, ec, eo;
    model(w, a, b, ci, sb, es, ec, eo);
    check({tag, "_sum"}, 32'(s), es);
    check({tag, "_cout"}, 32'(co), ec);
    check({tag, "_ovf"}, 32'(ov), eo);
  endtask
  task automatic start8(input int a, input int b, input int ci, input int sb);
    @(negedge clk);
    b8.a = 8'(a);
    b8.b = 8'(b);
    b8.cin = 1'(ci);
    b8.sub = 1'(sb);
    b8.start = 1;
  endtask
  task automatic wait_done8(output int lat);
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      b8.start = 0;
      if (b8.done) lat = i;
    end
  endtask
  task automatic op8(input string tag, input int a, input int b, input int ci, input int sb);
    int lat;
    start8(a, b, ci, sb);
    wait_done8(lat);
    check({tag, "_lat"}, lat, 5);
    chk_res(tag, 8, b8.sum, b8.cout, b8.ovf, a, b, ci, sb);
  endtask
  task automatic sweep_one(input int a, input int b, input int ci, input int sb);
    int l1, l2, l4;
    l1 = 0;
    l2 = 0;
    l4 = 0;
    @(negedge clk);
    b41.a = 4'(a); b41.b = 4'(b); b41.cin = 1'(ci); b41.sub = 1'(sb); b41.start = 1;
    b42.a = 4'(a); b42.b = 4'(b); b42.cin = 1'(ci); b42.sub = 1'(sb); b42.start = 1;
    b44.a = 4'(a); b44.b = 4'(b); b44.cin = 1'(ci); b44.sub = 1'(sb); b44.start = 1;
    for (int i = 1; i <= 10 && (l1 == 0 || l2 == 0 || l4 == 0); i++) begin
      @(negedge clk);
      b41.start = 0;
      b42.start = 0;
      b44.start = 0;
      if (b41.done && l1 == 0) begin
        l1 = i;
        chk_res("d1", 4, 8'(b41.sum), b41.cout, b41.ovf, a, b, ci, sb);
      end
      if (b42.done && l2 == 0) begin
        l2 = i;
        chk_res("d2", 4, 8'(b42.sum), b42.cout, b42.ovf, a, b, ci, sb);
      end
      if (b44.done && l4 == 0) begin
        l4 = i;
        chk_res("d4", 4, 8'(b44.sum), b44.cout, b44.ovf, a, b, ci, sb);
      end
    end
    check("d1_lat", l1, 5);
    check("d2_lat", l2, 3);
    check("d4_lat", l4, 2);
  endtask
  initial begin
    int lat, nd;
    b8.start = 0; b8.a = 0; b8.b = 0; b8.cin = 0; b8.sub = 0;
    b41.start = 0; b41.a = 0; b41.b = 0; b41.cin = 0; b41.sub = 0;
    b42.start = 0; b42.a = 0; b42.b = 0; b42.cin = 0; b42.sub = 0;
    b44.start = 0; b44.a = 0; b44.b = 0; b44.cin = 0; b44.sub = 0;
    #2 rst = 1;
    @(negedge clk);
    check("rst_ready", 32'(b8.ready), 1);
    check("rst_busy", 32'(b8.busy), 0);
    check("rst_done", 32'(b8.done), 0);
    check("rst_sum", 32'(b8.sum), 0);
    check("rst_cout", 32'(b8.cout), 0);
    check("rst_ovf", 32'(b8.ovf), 0);
    @(negedge clk);
    rst = 0;
    op8("t1", 'h5A, 'h33, 0, 0);
    check("t1_sum_k", 32'(b8.sum), 'h8D);
    check("t1_cout_k", 32'(b8.cout), 0);
    check("t1_ovf_k", 32'(b8.ovf), 1);
    @(negedge clk);
    check("t1_ready", 32'(b8.ready), 1);
    check("t1_done_off", 32'(b8.done), 0);
    op8("t2a", 'hFF, 'h01, 0, 0);
    check("t2a_sum_k", 32'(b8.sum), 'h00);
    op8("t2b", 'h7F, 'h00, 1, 0);
    check("t2b_sum_k", 32'(b8.sum), 'h80);
    op8("t3a", 'h10, 'h20, 0, 1);
    check("t3a_sum_k", 32'(b8.sum), 'hF0);
    op8("t3b", 'h80, 'h01, 0, 1);
    check("t3b_sum_k", 32'(b8.sum), 'h7F);
    start8('h01, 'h01, 0, 0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b8.a = 8'hAA;
      b8.start = 1;
      if (b8.done) begin
        nd++;
        check("t4_sum", 32'(b8.sum), 'h02);
      end
    end
    check("t4_ndone", nd, 1);
    check("t4_ready", 32'(b8.ready), 1);
    wait_done8(lat);
    check("t4_lat", lat, 5);
    chk_res("t4b", 8, b8.sum, b8.cout, b8.ovf, 'hAA, 'h01, 0, 0);
    start8('h5A, 'h33, 0, 0);
    @(negedge clk);
    b8.start = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("t5_ready", 32'(b8.ready), 1);
    check("t5_busy", 32'(b8.busy), 0);
    check("t5_done", 32'(b8.done), 0);
    check("t5_sum", 32'(b8.sum), 0);
    check("t5_cout", 32'(b8.cout), 0);
    check("t5_ovf", 32'(b8.ovf), 0);
    @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (b8.done) nd++;
    end
    check("t5_nodone", nd, 0);
    op8("t5b", 'h03, 'h04, 0, 0);
    repeat (40) op8("rnd", $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(1, 0), $urandom_range(1, 0));
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          for (int sb = 0; sb < 2; sb++) sweep_one(a, b, ci, sb);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
